// File: rtl/audio_mix_pkg.sv
// rtl/audio_mix_pkg.sv - shared types, widths and saturation helper for the audio mixer
package audio_mix_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_MAC,
    S_NEXT,
    S_OUT
  } state_t;

  localparam int VOICE_W  = 16;
  localparam int GAIN_W   = 8;
  localparam int OUT_W    = 24;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 8'h80;

  // signed voice x signed-extended unsigned gain
  localparam int PROD_W   = VOICE_W + GAIN_W + 1;
  // accumulators are sign-extended to this width before saturation
  localparam int SAT_IN_W = 32;

  // Clamp a wide signed accumulator into the 24-bit output range.
  function automatic logic signed [OUT_W-1:0] sat24(input logic signed [SAT_IN_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > 32'sh007F_FFFF) begin
      r = 24'sh7F_FFFF;
    end else if (v < -32'sh0080_0000) begin
      r = 24'sh80_0000;
    end else begin
      r = v[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_mix_mac.sv
// rtl/audio_mix_mac.sv - shared gain multiplier, stereo accumulators and output saturation
module audio_mix_mac
  import audio_mix_pkg::*;
#(
  parameter int ACC_W = 28
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      mac_en,
  input  logic                      load_out,
  input  logic signed [VOICE_W-1:0] sample,
  input  logic [GAIN_W-1:0]         gain_l,
  input  logic [GAIN_W-1:0]         gain_r,
  output logic signed [OUT_W-1:0]   out_l,
  output logic signed [OUT_W-1:0]   out_r
);

  // The single multiplier serves left on the mac_en cycle and right on the
  // cycle after it (always a NEXT cycle, where the multiplier is otherwise
  // idle). gain_r is captured on the mac_en cycle so both channels see the
  // gains as they stood in MAC.
  logic                      r_pend;
  logic [GAIN_W-1:0]         gain_r_q;
  logic [GAIN_W-1:0]         gain_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [PROD_W:0]    contrib;
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;

  assign gain_sel = r_pend ? gain_r_q : gain_l;
  assign prod     = sample * $signed({1'b0, gain_sel});
  assign contrib  = {prod, 1'b0};

  // Accumulate left then right contributions; clear at frame start.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_l    <= '0;
      acc_r    <= '0;
      r_pend   <= 1'b0;
      gain_r_q <= '0;
    end else begin
      r_pend <= mac_en;
      if (mac_en) begin
        acc_l    <= acc_l + ACC_W'(contrib);
        gain_r_q <= gain_r;
      end
      if (r_pend) begin
        acc_r <= acc_r + ACC_W'(contrib);
      end
    end
  end

  // Saturate and hold the stereo result until the next frame loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_l <= '0;
      out_r <= '0;
    end else if (load_out) begin
      out_l <= sat24(SAT_IN_W'(acc_l));
      out_r <= sat24(SAT_IN_W'(acc_r));
    end
  end

endmodule

// File: rtl/audio_mix_sched.sv
// rtl/audio_mix_sched.sv - per-sample voice polling scheduler, gain registers and mixer top
module audio_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk100,
  input  logic                          rst,
  input  logic                          isnew_sample,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_addr,
  input  logic [GAIN_W-1:0]             cfg_gain_l,
  input  logic [GAIN_W-1:0]             cfg_gain_r,
  input  logic                          cfg_en,
  output logic                          vreq,
  output logic [$clog2(NUM_VOICES)-1:0] vsel,
  input  logic                          vack,
  input  logic [VOICE_W-1:0]            vdata,
  output logic [OUT_W-1:0]              audio_l_out,
  output logic [OUT_W-1:0]              audio_r_out,
  output logic                          hphone_valid,
  output logic                          busy,
  output logic                          overrun_err,
  output logic                          timeout_err
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int ACC_W  = 26 + IDX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  logic [GAIN_W-1:0]         gain_l_q [NUM_VOICES];
  logic [GAIN_W-1:0]         gain_r_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]     en_q;

  state_t                    state;
  state_t                    state_nx;
  logic [IDX_W-1:0]          idx;
  logic [TCNT_W-1:0]         tcnt;
  logic signed [VOICE_W-1:0] sample_q;
  logic                      mac_clr;
  logic                      mac_en;
  logic                      load_out;
  logic signed [OUT_W-1:0]   mix_l;
  logic signed [OUT_W-1:0]   mix_r;

  // Per-voice gain/enable registers; writes land on the next cycle, any state.
  always_ff @(posedge clk100) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        gain_l_q[v] <= UNITY_GAIN;
        gain_r_q[v] <= UNITY_GAIN;
      end
      en_q <= '0;
    end else if (cfg_we && (int'(cfg_addr) < NUM_VOICES)) begin
      gain_l_q[cfg_addr] <= cfg_gain_l;
      gain_r_q[cfg_addr] <= cfg_gain_r;
      en_q[cfg_addr]     <= cfg_en;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_nx = state;
    vreq     = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (isnew_sample) begin
          mac_clr  = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (en_q[idx]) begin
          vreq     = 1'b1;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_NEXT;
        end
      end
      S_WAIT: begin
        if (vack || (tcnt == TCNT_MAX)) begin
          state_nx = S_MAC;
        end
      end
      S_MAC: begin
        mac_en   = 1'b1;
        state_nx = S_NEXT;
      end
      S_NEXT: begin
        state_nx = (idx == LAST_IDX) ? S_OUT : S_REQ;
      end
      S_OUT: begin
        load_out = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Voice index, WAIT counter, sample latch, strobe and sticky error flags.
  always_ff @(posedge clk100) begin
    if (rst) begin
      idx          <= '0;
      tcnt         <= '0;
      sample_q     <= '0;
      hphone_valid <= 1'b0;
      overrun_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      hphone_valid <= (state == S_OUT);
      if (isnew_sample && (state != S_IDLE)) begin
        overrun_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (isnew_sample) begin
            idx <= '0;
          end
        end
        S_REQ: begin
          // first WAIT cycle counts as 1
          tcnt <= TCNT_W'(1);
        end
        S_WAIT: begin
          if (vack) begin
            sample_q <= vdata;
          end else if (tcnt == TCNT_MAX) begin
            sample_q    <= '0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        S_NEXT: begin
          if (idx != LAST_IDX) begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          // vsel reads 0 whenever the scheduler is idle
          idx <= '0;
        end
        default: ;
      endcase
    end
  end

  audio_mix_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk100),
    .rst      (rst),
    .clr      (mac_clr),
    .mac_en   (mac_en),
    .load_out (load_out),
    .sample   (sample_q),
    .gain_l   (gain_l_q[idx]),
    .gain_r   (gain_r_q[idx]),
    .out_l    (mix_l),
    .out_r    (mix_r)
  );

  assign audio_l_out = mix_l;
  assign audio_r_out = mix_r;
  assign vsel        = idx;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_audio_mix_sched.sv
// tb/tb_audio_mix_sched.sv - self-checking bench for audio_mix_sched
module tb_audio_mix_sched;

  localparam int NV = 4;
  localparam int TO = 64;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        isnew_sample;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_gain_l;
  logic [7:0]  cfg_gain_r;
  logic        cfg_en;
  logic        vreq;
  logic [1:0]  vsel;
  logic        vack;
  logic [15:0] vdata;
  logic [23:0] audio_l_out;
  logic [23:0] audio_r_out;
  logic        hphone_valid;
  logic        busy;
  logic        overrun_err;
  logic        timeout_err;

  audio_mix_sched #(
    .NUM_VOICES (NV),
    .TIMEOUT    (TO)
  ) dut (
    .clk100       (clk100),
    .rst          (rst),
    .isnew_sample (isnew_sample),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_gain_l   (cfg_gain_l),
    .cfg_gain_r   (cfg_gain_r),
    .cfg_en       (cfg_en),
    .vreq         (vreq),
    .vsel         (vsel),
    .vack         (vack),
    .vdata        (vdata),
    .audio_l_out  (audio_l_out),
    .audio_r_out  (audio_r_out),
    .hphone_valid (hphone_valid),
    .busy         (busy),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk100 = ~clk100;

  // reference state: register file contents and voice behaviour (k=0 never acks)
  bit      m_en [NV];
  int      m_gl [NV];
  int      m_gr [NV];
  int      m_k  [NV];
  shortint m_d  [NV];
  bit      m_terr;
  bit      m_oerr;

  int n_tests = 0;
  int n_fail  = 0;

  // results of the most recent frame
  int          f_cyc;
  int          f_cnt;
  logic [23:0] f_l, f_r, f_hl, f_hr;
  bit          f_rz;
  // pending mid-frame register write
  int w_addr, w_gl, w_gr;
  bit w_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] clip(input longint s);
    longint c;
    c = s;
    if (c > 64'sd8388607) c = 64'sd8388607;
    if (c < -64'sd8388608) c = -64'sd8388608;
    return c[23:0];
  endfunction

  // Expected mix and strobe cycle from the per-voice cost rules.
  task automatic model_frame(output logic [23:0] el, output logic [23:0] er,
                             output int ec, output bit eto);
    longint sl, sr;
    sl = 0; sr = 0; ec = 2; eto = 0;
    for (int v = 0; v < NV; v++) begin
      if (!m_en[v]) begin
        ec += 2;
      end else if (m_k[v] == 0) begin
        ec += 3 + TO;
        eto = 1;
      end else begin
        ec += 3 + m_k[v];
        sl += longint'(m_d[v]) * longint'(m_gl[v]) * 2;
        sr += longint'(m_d[v]) * longint'(m_gr[v]) * 2;
      end
    end
    el = clip(sl);
    er = clip(sr);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_en[v] = 0; m_gl[v] = 'h80; m_gr[v] = 'h80;
    end
    m_terr = 0; m_oerr = 0;
  endtask

  task automatic cfg_write(input int a, input int gl, input int gr, input bit e);
    @(negedge clk100);
    cfg_we = 1; cfg_addr = 2'(a); cfg_gain_l = 8'(gl); cfg_gain_r = 8'(gr); cfg_en = e;
    m_gl[a] = gl; m_gr[a] = gr; m_en[a] = e;
    @(negedge clk100);
    cfg_we = 0;
  endtask

  // One frame: cycle 0 is the isnew_sample cycle; optional mid-frame write,
  // extra isnew_sample and reset at given cycle numbers (-1 = none).
  task automatic run_frame(input int wr_at, input int isn_at, input int rst_at);
    int lim;
    lim = 2 + NV * (3 + TO) + 20;
    f_cyc = -1; f_cnt = 0; f_l = 0; f_r = 0; f_rz = 0;
    @(negedge clk100);
    isnew_sample = 1;
    @(negedge clk100);
    isnew_sample = 0;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      if (hphone_valid === 1'b1) begin
        f_cnt++;
        if (f_cyc < 0) begin
          f_cyc = cyc; f_l = audio_l_out; f_r = audio_r_out;
        end
      end
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        f_rz = ({audio_l_out, audio_r_out, hphone_valid, busy, vreq, vsel,
                 overrun_err, timeout_err} === '0);
      end
      if (cyc == wr_at) begin
        cfg_we = 1; cfg_addr = 2'(w_addr); cfg_gain_l = 8'(w_gl);
        cfg_gain_r = 8'(w_gr); cfg_en = w_en;
        m_gl[w_addr] = w_gl; m_gr[w_addr] = w_gr; m_en[w_addr] = w_en;
      end else begin
        cfg_we = 0;
      end
      isnew_sample = (cyc == isn_at);
      rst = (cyc == rst_at);
      if (f_cyc >= 0 && cyc >= f_cyc + 8) break;
      @(negedge clk100);
    end
    cfg_we = 0; isnew_sample = 0; rst = 0;
    f_hl = audio_l_out; f_hr = audio_r_out;
  endtask

  task automatic frame_checks(input string tag);
    logic [23:0] el, er;
    int ec;
    bit eto;
    model_frame(el, er, ec, eto);
    m_terr = m_terr | eto;
    chk({tag, "_cycle"}, 64'(f_cyc), 64'(ec));
    chk({tag, "_strobes"}, 64'(f_cnt), 64'd1);
    chk({tag, "_l"}, 64'(f_l), 64'(el));
    chk({tag, "_r"}, 64'(f_r), 64'(er));
    chk({tag, "_hold"}, 64'({f_hl, f_hr}), 64'({el, er}));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(m_terr));
    chk({tag, "_overrun_err"}, 64'(overrun_err), 64'(m_oerr));
  endtask

  // voice generators: answer a request after m_k WAIT cycles with m_d
  initial begin
    int v;
    vack = 0; vdata = 0;
    forever begin
      @(negedge clk100);
      vack = 0;
      if (vreq === 1'b1) begin
        v = int'(vsel);
        if (m_k[v] != 0) begin
          repeat (m_k[v]) @(negedge clk100);
          vack = 1; vdata = m_d[v];
        end
      end
    end
  end

  initial begin
    rst = 1; isnew_sample = 0; cfg_we = 0; cfg_addr = 0;
    cfg_gain_l = 0; cfg_gain_r = 0; cfg_en = 0;
    for (int v = 0; v < NV; v++) begin
      m_k[v] = 1; m_d[v] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk100);
    rst = 0;
    @(negedge clk100);
    chk("reset_outputs", 64'({audio_l_out, audio_r_out, hphone_valid, busy, vreq, vsel,
                              overrun_err, timeout_err}), 64'd0);

    // all voices disabled
    run_frame(-1, -1, -1);
    chk("all_off_cycle10", 64'(f_cyc), 64'd10);
    frame_checks("all_off");

    // unity passthrough on voice 0
    m_d[0] = 16'sh1234; m_k[0] = 1;
    cfg_write(0, 'h80, 'h80, 1);
    run_frame(-1, -1, -1);
    chk("unity_l_const", 64'(f_l), 64'h123400);
    chk("unity_cycle12", 64'(f_cyc), 64'd12);
    frame_checks("unity");

    // saturation with hard-left pan, positive then negative full scale
    for (int v = 0; v < NV; v++) begin
      m_d[v] = 16'sh7FFF; m_k[v] = v + 1;
      cfg_write(v, 'hFF, 'h00, 1);
    end
    run_frame(-1, -1, -1);
    chk("sat_pos_l_const", 64'(f_l), 64'h7FFFFF);
    frame_checks("sat_pos");
    for (int v = 0; v < NV; v++) m_d[v] = -16'sh8000;
    run_frame(-1, -1, -1);
    chk("sat_neg_l_const", 64'(f_l), 64'h800000);
    frame_checks("sat_neg");

    // voice 2 never answers
    for (int v = 0; v < NV; v++) begin
      m_d[v] = shortint'(16'h0400 * (v + 1) - 16'h0900); m_k[v] = 2;
      cfg_write(v, 'h80, 'h40, 1);
    end
    m_k[2] = 0;
    run_frame(-1, -1, -1);
    chk("timeout_flag", 64'(timeout_err), 64'd1);
    frame_checks("timeout");

    // second isnew_sample five cycles into the frame
    m_k[2] = 3;
    m_oerr = 1;
    run_frame(-1, 5, -1);
    frame_checks("overrun");

    // voice 3 gain_l halved while voice 1 is in WAIT (cycles 6..10)
    m_k[0] = 1; m_k[1] = 5;
    w_addr = 3; w_gl = 'h40; w_gr = 'h40; w_en = 1;
    run_frame(7, -1, -1);
    frame_checks("midcfg");

    // reset while waiting on voice 1, then a clean frame
    m_k[1] = 0;
    run_frame(-1, -1, 8);
    chk("rst_outputs_zero", 64'(f_rz), 64'd1);
    chk("rst_no_strobe", 64'(f_cnt), 64'd0);
    model_reset();
    run_frame(-1, -1, -1);
    chk("post_rst_cycle10", 64'(f_cyc), 64'd10);
    frame_checks("post_rst");

    // randomized frames
    for (int t = 0; t < 8; t++) begin
      for (int v = 0; v < NV; v++) begin
        m_d[v] = shortint'($urandom);
        m_k[v] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
        cfg_write(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)));
      end
      run_frame(-1, -1, -1);
      frame_checks($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
